// File: rtl/prog_loader_if.sv
// Instruction-memory write port and loader status bundle.
// The loader drives it (master); the memory/CPU side observes it (slave).
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [15:0]       byte_count;

  modport master (
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, byte_count
  );

  modport slave (
    input mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, byte_count
  );
endinterface

// File: rtl/prog_loader.sv
// UART program loader: 8N1 receiver plus frame parser that writes a
// checksummed image (A5, LEN_LO, LEN_HI, payload, CHK) into instruction
// memory and keeps the CPU held until a complete, verified image is present.
module prog_loader #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          UART_RX,
  prog_loader_if.master bus
);

  localparam int CPB     = CLK_HZ / BAUD;
  localparam int HALF    = CPB / 2;
  localparam int CNT_W   = $clog2(CPB + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int MAX_LEN = 2 ** ADDR_W;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t  rx_state_r, rx_next_s;
  logic       sync1_r, sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0] bit_idx_r;
  logic [7:0] shreg_r;
  logic       rx_valid_r;
  logic       frame_err_r;
  logic       tick_s;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= UART_RX;
      sync2_r <= sync1_r;
    end
  end

  // Receiver next state: half-bit start check, eight data bits, stop bit.
  always_comb begin
    rx_next_s = rx_state_r;
    tick_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (!sync2_r) rx_next_s = RX_START;
        else          rx_next_s = RX_IDLE;
      end
      RX_START: begin
        tick_s = (cnt_r == CNT_W'(HALF - 1));
        if (tick_s) rx_next_s = sync2_r ? RX_IDLE : RX_DATA;
        else        rx_next_s = RX_START;
      end
      RX_DATA: begin
        tick_s = (cnt_r == CNT_W'(CPB - 1));
        if (tick_s && bit_idx_r == 3'd7) rx_next_s = RX_STOP;
        else                             rx_next_s = RX_DATA;
      end
      RX_STOP: begin
        tick_s = (cnt_r == CNT_W'(CPB - 1));
        if (tick_s) rx_next_s = sync2_r ? RX_IDLE : RX_BREAK;
        else        rx_next_s = RX_STOP;
      end
      RX_BREAK: begin
        // After a bad stop bit, wait for the line to return high so the
        // still-low line is not mistaken for a new start bit.
        if (sync2_r) rx_next_s = RX_IDLE;
        else         rx_next_s = RX_BREAK;
      end
      default: rx_next_s = RX_IDLE;
    endcase
  end

  // Receiver state, bit timer, shift register and one-cycle result pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_r  <= RX_IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shreg_r     <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_state_r <= rx_next_s;
      if (rx_state_r == RX_IDLE || rx_state_r == RX_BREAK || tick_s) cnt_r <= '0;
      else                                                          cnt_r <= cnt_r + CNT_W'(1);
      if (rx_state_r == RX_START) begin
        bit_idx_r <= 3'd0;
      end else if (rx_state_r == RX_DATA && tick_s) begin
        shreg_r   <= {sync2_r, shreg_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
      rx_valid_r  <= (rx_state_r == RX_STOP) && tick_s && sync2_r;
      frame_err_r <= (rx_state_r == RX_STOP) && tick_s && !sync2_r;
    end
  end

  // ---------------------------------------------------------------- parser
  typedef enum logic [2:0] {ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD,
                            ST_CHECK, ST_DONE, ST_ERR} state_t;

  state_t            state_r, next_s;
  logic [15:0]       len_r;
  logic [7:0]        acc_r;
  logic [TO_W-1:0]   idle_cnt_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic              cpu_hold_r;
  logic              load_done_r;
  logic              load_err_r;
  logic [15:0]       byte_count_r;
  logic              start_s;
  logic              write_s;
  logic              active_s;
  logic              timeout_s;
  logic [15:0]       len_next_s;

  // Frame parser next state plus start/write strobes.
  always_comb begin
    next_s     = state_r;
    start_s    = 1'b0;
    write_s    = 1'b0;
    active_s   = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                 (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);
    timeout_s  = active_s && (idle_cnt_r == TO_W'(TIMEOUT_CYC));
    len_next_s = {rx_byte_hi_s(), len_r[7:0]};
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (rx_valid_r && shreg_r == 8'hA5) begin
          next_s  = ST_LEN_LO;
          start_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid_r)                    next_s = ST_LEN_HI;
        else if (frame_err_r || timeout_s) next_s = ST_ERR;
        else                               next_s = ST_LEN_LO;
      end
      ST_LEN_HI: begin
        if (rx_valid_r) begin
          if ({1'b0, len_next_s} > 17'(MAX_LEN)) next_s = ST_ERR;
          else if (len_next_s == 16'd0)          next_s = ST_CHECK;
          else                                   next_s = ST_PAYLOAD;
        end else if (frame_err_r || timeout_s) begin
          next_s = ST_ERR;
        end else begin
          next_s = ST_LEN_HI;
        end
      end
      ST_PAYLOAD: begin
        if (mem_we_r && (byte_count_r + 16'd1) == len_r) begin
          next_s = ST_CHECK;
        end else if (rx_valid_r) begin
          write_s = 1'b1;
          next_s  = ST_PAYLOAD;
        end else if (frame_err_r || timeout_s) begin
          next_s = ST_ERR;
        end else begin
          next_s = ST_PAYLOAD;
        end
      end
      ST_CHECK: begin
        if (rx_valid_r)                    next_s = ((acc_r + shreg_r) == 8'h00) ? ST_DONE : ST_ERR;
        else if (frame_err_r || timeout_s) next_s = ST_ERR;
        else                               next_s = ST_CHECK;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // High length byte as seen on the receiver output this cycle.
  function automatic logic [7:0] rx_byte_hi_s();
    return shreg_r;
  endfunction

  // Parser state, length/checksum, idle timer and registered memory/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      len_r        <= 16'd0;
      acc_r        <= 8'h00;
      idle_cnt_r   <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'h00;
      cpu_hold_r   <= 1'b1;
      load_done_r  <= 1'b0;
      load_err_r   <= 1'b0;
      byte_count_r <= 16'd0;
    end else begin
      state_r    <= next_s;
      cpu_hold_r <= (next_s != ST_DONE);
      mem_we_r   <= write_s;

      if (!active_s || rx_valid_r) idle_cnt_r <= '0;
      else                         idle_cnt_r <= idle_cnt_r + TO_W'(1);

      if (state_r == ST_LEN_LO && rx_valid_r) len_r[7:0]  <= shreg_r;
      if (state_r == ST_LEN_HI && rx_valid_r) len_r[15:8] <= shreg_r;

      if (start_s) begin
        load_done_r  <= 1'b0;
        load_err_r   <= 1'b0;
        byte_count_r <= 16'd0;
        mem_addr_r   <= '0;
        acc_r        <= 8'h00;
      end else begin
        if (next_s == ST_DONE && state_r != ST_DONE) load_done_r <= 1'b1;
        if (next_s == ST_ERR && state_r != ST_ERR)   load_err_r  <= 1'b1;
        if (write_s) begin
          mem_wdata_r <= shreg_r;
          acc_r       <= acc_r + shreg_r;
        end
        // Address/count advance after the write cycle; the address saturates
        // so a full-size image ends on the top address instead of wrapping.
        if (mem_we_r) begin
          byte_count_r <= byte_count_r + 16'd1;
          if (mem_addr_r != {ADDR_W{1'b1}}) mem_addr_r <= mem_addr_r + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.cpu_hold   = cpu_hold_r;
  assign bus.load_done  = load_done_r;
  assign bus.load_err   = load_err_r;
  assign bus.byte_count = byte_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: 10 clocks per bit, 1000-cycle timeout.
module tb_prog_loader;

  localparam int TB_CPB = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic UART_RX = 1'b1;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [7:0] frm [$];
  logic [9:0] wr_addr [$];
  logic [7:0] wr_data [$];

  prog_loader_if #(.ADDR_W(10)) bus ();

  prog_loader #(
    .CLK_HZ(1000000), .BAUD(100000), .ADDR_W(10), .TIMEOUT_CYC(1000)
  ) dut (
    .CLK(CLK), .RST(RST), .UART_RX(UART_RX), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Log every memory write strobe seen by the memory side.
  always @(posedge CLK) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    UART_RX = 1'b0;
    repeat (TB_CPB) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (TB_CPB) @(posedge CLK);
    end
    UART_RX = stop;
    repeat (TB_CPB) @(posedge CLK);
    UART_RX = 1'b1;
    repeat (TB_CPB) @(posedge CLK);
  endtask

  task automatic send_q();
    foreach (frm[i]) send_byte(frm[i], 1'b1);
  endtask

  task automatic settle();
    repeat (5) @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #23;
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    check("rst_byte_count", 32'(bus.byte_count), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge CLK);
    RST = 1'b0;
    repeat (10) @(posedge CLK);

    // Good 3-byte frame.
    clear_log();
    frm = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'hFA};
    send_q();
    settle();
    check("t1_nwrites", 32'(wr_addr.size()), 32'd3);
    check("t1_addr0", 32'(wr_addr[0]), 32'd0);
    check("t1_addr1", 32'(wr_addr[1]), 32'd1);
    check("t1_addr2", 32'(wr_addr[2]), 32'd2);
    check("t1_data0", 32'(wr_data[0]), 32'h01);
    check("t1_data1", 32'(wr_data[1]), 32'h02);
    check("t1_data2", 32'(wr_data[2]), 32'h03);
    check("t1_load_done", 32'(bus.load_done), 32'd1);
    check("t1_load_err", 32'(bus.load_err), 32'd0);
    check("t1_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("t1_byte_count", 32'(bus.byte_count), 32'd3);

    // Bad checksum.
    clear_log();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h00};
    send_q();
    settle();
    check("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    check("t2_data1", 32'(wr_data[1]), 32'h20);
    check("t2_load_err", 32'(bus.load_err), 32'd1);
    check("t2_load_done", 32'(bus.load_done), 32'd0);
    check("t2_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("t2_byte_count", 32'(bus.byte_count), 32'd2);

    // Leading junk, then empty frame.
    clear_log();
    frm = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    settle();
    check("t3_nwrites", 32'(wr_addr.size()), 32'd0);
    check("t3_load_done", 32'(bus.load_done), 32'd1);
    check("t3_load_err", 32'(bus.load_err), 32'd0);
    check("t3_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("t3_byte_count", 32'(bus.byte_count), 32'd0);

    // Oversize length (1025), then a good 1-byte frame.
    clear_log();
    send_byte(8'hA5, 1'b1);
    #1;
    check("t4_hold_on_restart", 32'(bus.cpu_hold), 32'd1);
    check("t4_done_cleared", 32'(bus.load_done), 32'd0);
    frm = '{8'h01, 8'h04};
    send_q();
    settle();
    check("t4_len_err", 32'(bus.load_err), 32'd1);
    check("t4_len_nwrites", 32'(wr_addr.size()), 32'd0);
    frm = '{8'hA5, 8'h01, 8'h00, 8'h7F, 8'h81};
    send_q();
    settle();
    check("t4_nwrites", 32'(wr_addr.size()), 32'd1);
    check("t4_addr0", 32'(wr_addr[0]), 32'd0);
    check("t4_data0", 32'(wr_data[0]), 32'h7F);
    check("t4_load_done", 32'(bus.load_done), 32'd1);
    check("t4_byte_count", 32'(bus.byte_count), 32'd1);

    // Inter-byte timeout.
    clear_log();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h11};
    send_q();
    repeat (500) @(posedge CLK);
    #1;
    check("t5_no_early_timeout", 32'(bus.load_err), 32'd0);
    check("t5_nwrites", 32'(wr_addr.size()), 32'd1);
    repeat (600) @(posedge CLK);
    #1;
    check("t5_timeout_err", 32'(bus.load_err), 32'd1);
    check("t5_cpu_hold", 32'(bus.cpu_hold), 32'd1);

    // LEN = MAX_LEN accepted, then a payload byte with a bad stop bit.
    clear_log();
    frm = '{8'hA5, 8'h00, 8'h04};
    send_q();
    settle();
    check("t6_maxlen_ok", 32'(bus.load_err), 32'd0);
    send_byte(8'h33, 1'b0);
    settle();
    check("t6_frame_err", 32'(bus.load_err), 32'd1);
    check("t6_nwrites", 32'(wr_addr.size()), 32'd0);

    // Reset in the middle of the payload.
    clear_log();
    frm = '{8'hA5, 8'h03, 8'h00, 8'h01};
    send_q();
    settle();
    check("t7_pre_addr", 32'(bus.mem_addr), 32'd1);
    check("t7_pre_count", 32'(bus.byte_count), 32'd1);
    UART_RX = 1'b0;
    repeat (25) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("t7_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("t7_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("t7_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("t7_byte_count", 32'(bus.byte_count), 32'd0);
    check("t7_load_done", 32'(bus.load_done), 32'd0);
    check("t7_mem_we", 32'(bus.mem_we), 32'd0);
    UART_RX = 1'b1;
    repeat (3) @(posedge CLK);
    RST = 1'b0;
    repeat (30) @(posedge CLK);

    // Short start glitch inside a frame must not become a payload byte.
    clear_log();
    frm = '{8'hA5, 8'h01, 8'h00};
    send_q();
    UART_RX = 1'b0;
    repeat (3) @(posedge CLK);
    UART_RX = 1'b1;
    repeat (150) @(posedge CLK);
    frm = '{8'h55, 8'hAB};
    send_q();
    settle();
    check("t8_nwrites", 32'(wr_addr.size()), 32'd1);
    check("t8_data0", 32'(wr_data[0]), 32'h55);
    check("t8_load_done", 32'(bus.load_done), 32'd1);
    check("t8_load_err", 32'(bus.load_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
